// File: rtl/ifu_npc_pkg.sv
// Shared constants and helpers for the fetch stage: next-PC select codes,
// the reset fetch address and the branch-offset sign extension.
package ifu_npc_pkg;

  typedef enum logic [1:0] {
    NPC_PC4 = 2'd0,
    NPC_BR  = 2'd1,
    NPC_J   = 2'd2,
    NPC_JR  = 2'd3
  } npc_op_e;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] NOP      = 32'h0000_0000;

  // 16-bit word offset to a byte offset, sign-extended to 32 bits.
  function automatic logic [31:0] br_offset(input logic [15:0] imm);
    br_offset = {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/ifu_npc_calc.sv
// Combinational next-PC selection: sequential, conditional branch,
// absolute jump inside the current 256 MB region, and register jump.
module npc_calc
  import ifu_npc_pkg::*;
(
  input  logic [1:0]  i_npc_op,
  input  logic        i_cmp_out,
  input  logic [31:0] i_f_pc,
  input  logic [31:0] i_d_pc,
  input  logic [31:0] i_d_instr,
  input  logic [31:0] i_d_rs_val,
  output logic [31:0] o_npc
);

  logic [31:0] w_pc4;
  logic [31:0] w_br_target;
  logic [31:0] w_j_target;

  assign w_pc4       = i_f_pc + 32'd4;
  // Branch and jump targets are relative to the instruction in D, not to f_pc.
  assign w_br_target = i_d_pc + 32'd4 + br_offset(i_d_instr[15:0]);
  assign w_j_target  = {i_d_pc[31:28], i_d_instr[25:0], 2'b00};

  always_comb begin
    o_npc = w_pc4;
    case (i_npc_op)
      NPC_PC4: o_npc = w_pc4;
      NPC_BR:  o_npc = i_cmp_out ? w_br_target : w_pc4;
      NPC_J:   o_npc = w_j_target;
      NPC_JR:  o_npc = i_d_rs_val;
      default: o_npc = w_pc4;
    endcase
  end

endmodule

// File: rtl/ifu_npc.sv
// Fetch stage: PC register plus F/D pipeline register. The delay-slot
// instruction is never flushed; a stall freezes PC and F/D together.
module ifu_npc
  import ifu_npc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  npc_op,
  input  logic        cmp_out,
  input  logic [31:0] d_rs_val,
  input  logic [31:0] f_instr,
  output logic [31:0] f_pc,
  output logic [31:0] d_instr,
  output logic [31:0] d_pc,
  output logic [31:0] d_pc8
);

  logic [31:0] r_f_pc;
  logic [31:0] r_d_instr;
  logic [31:0] r_d_pc;
  logic [31:0] w_npc;

  npc_calc u_npc_calc (
    .i_npc_op   (npc_op),
    .i_cmp_out  (cmp_out),
    .i_f_pc     (r_f_pc),
    .i_d_pc     (r_d_pc),
    .i_d_instr  (r_d_instr),
    .i_d_rs_val (d_rs_val),
    .o_npc      (w_npc)
  );

  // A redirect held under stall is simply recomputed next cycle from the
  // unchanged D contents, so no pending-redirect state is needed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_f_pc    <= RESET_PC;
      r_d_instr <= NOP;
      r_d_pc    <= 32'h0000_0000;
    end else if (!stall) begin
      r_f_pc    <= w_npc;
      r_d_instr <= f_instr;
      r_d_pc    <= r_f_pc;
    end
  end

  assign f_pc    = r_f_pc;
  assign d_instr = r_d_instr;
  assign d_pc    = r_d_pc;
  assign d_pc8   = r_d_pc + 32'd8;

endmodule

// File: tb/tb_ifu_npc.sv
// Bench for ifu_npc: directed pipeline scenarios plus random stimulus,
// compared against an architectural fetch model.
module tb_ifu_npc;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [1:0]  npc_op;
  logic        cmp_out;
  logic [31:0] d_rs_val;
  logic [31:0] f_instr;
  logic [31:0] f_pc;
  logic [31:0] d_instr;
  logic [31:0] d_pc;
  logic [31:0] d_pc8;

  localparam logic [1:0] OP_PC4 = 2'd0;
  localparam logic [1:0] OP_BR  = 2'd1;
  localparam logic [1:0] OP_J   = 2'd2;
  localparam logic [1:0] OP_JR  = 2'd3;

  localparam logic [31:0] I_BR   = 32'h1000_FFFE;
  localparam logic [31:0] I_SLOT = 32'h2408_0001;
  localparam logic [31:0] I_JAL  = 32'h0C00_0C10;

  int n_total;
  int n_bad;

  // architectural model state
  logic [31:0] m_f_pc;
  logic [31:0] m_d_instr;
  logic [31:0] m_d_pc;

  ifu_npc dut (
    .clk      (clk),
    .reset    (reset),
    .stall    (stall),
    .npc_op   (npc_op),
    .cmp_out  (cmp_out),
    .d_rs_val (d_rs_val),
    .f_instr  (f_instr),
    .f_pc     (f_pc),
    .d_instr  (d_instr),
    .d_pc     (d_pc),
    .d_pc8    (d_pc8)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_npc(input logic [1:0] op, input logic c,
                                            input logic [31:0] rs);
    logic signed [31:0] off;
    longint unsigned     sum;
    off = $signed(m_d_instr[15:0]);
    case (op)
      OP_BR: begin
        if (c) sum = longint'(m_d_pc) + 4 + longint'(off) * 4;
        else   sum = longint'(m_f_pc) + 4;
      end
      OP_J:  sum = longint'(m_d_pc & 32'hF000_0000) + longint'(m_d_instr[25:0]) * 4;
      OP_JR: sum = longint'(rs);
      default: sum = longint'(m_f_pc) + 4;
    endcase
    model_npc = sum[31:0];
  endfunction

  task automatic check_state(input string tag);
    check({tag, ".f_pc"},    f_pc,    m_f_pc);
    check({tag, ".d_pc"},    d_pc,    m_d_pc);
    check({tag, ".d_instr"}, d_instr, m_d_instr);
    check({tag, ".d_pc8"},   d_pc8,   m_d_pc + 32'd8);
  endtask

  // Drive one cycle's inputs, advance the model, then check after the edge.
  task automatic step(input string tag, input logic [1:0] op, input logic c,
                      input logic [31:0] rs, input logic st, input logic [31:0] ins);
    logic [31:0] nxt;
    npc_op = op; cmp_out = c; d_rs_val = rs; stall = st; f_instr = ins;
    if (!st) begin
      nxt       = model_npc(op, c, rs);
      m_d_instr = ins;
      m_d_pc    = m_f_pc;
      m_f_pc    = nxt;
    end
    @(posedge clk);
    #1;
    check_state(tag);
  endtask

  // Asynchronous reset pulse mid-cycle with a taken branch and stall asserted.
  task automatic do_reset(input string tag);
    npc_op = OP_BR; cmp_out = 1'b1; stall = 1'b1;
    #1 reset = 1'b1;
    #1;
    m_f_pc = 32'h0000_3000; m_d_instr = 32'h0; m_d_pc = 32'h0;
    check({tag, ".async_f_pc"},    f_pc,    32'h0000_3000);
    check({tag, ".async_d_instr"}, d_instr, 32'h0);
    check({tag, ".async_d_pc"},    d_pc,    32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    check_state({tag, ".after"});
  endtask

  initial begin
    n_total = 0; n_bad = 0;
    reset = 1'b1; stall = 1'b0; npc_op = OP_PC4; cmp_out = 1'b0;
    d_rs_val = 32'h0; f_instr = 32'h0;
    m_f_pc = 32'h0000_3000; m_d_instr = 32'h0; m_d_pc = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.f_pc", f_pc, 32'h0000_3000);
    check("rst.d_instr", d_instr, 32'h0);
    check("rst.d_pc", d_pc, 32'h0);
    reset = 1'b0;

    // sequential fetch
    step("seq1", OP_PC4, 0, 0, 0, 32'h0);
    check("seq1.pc", f_pc, 32'h3004); check("seq1.dpc", d_pc, 32'h3000);
    step("seq2", OP_PC4, 0, 0, 0, 32'h0);
    check("seq2.pc", f_pc, 32'h3008); check("seq2.dpc", d_pc, 32'h3004);
    step("seq3", OP_PC4, 0, 0, 0, 32'h0);
    check("seq3.pc", f_pc, 32'h300C); check("seq3.dpc", d_pc, 32'h3008);

    // taken branch with delay slot
    do_reset("br_t");
    step("br_t.f1", OP_PC4, 0, 0, 0, 32'h0);
    step("br_t.f2", OP_PC4, 0, 0, 0, I_BR);
    check("br_t.dpc", d_pc, 32'h3004);
    step("br_t.go", OP_BR, 1, 0, 0, I_SLOT);
    check("br_t.target", f_pc, 32'h3000);
    check("br_t.slot_pc", d_pc, 32'h3008);
    check("br_t.slot_ins", d_instr, I_SLOT);
    step("br_t.next", OP_PC4, 0, 0, 0, 32'h0);
    check("br_t.next_pc", f_pc, 32'h3004);

    // not-taken branch
    do_reset("br_n");
    step("br_n.f1", OP_PC4, 0, 0, 0, 32'h0);
    step("br_n.f2", OP_PC4, 0, 0, 0, I_BR);
    step("br_n.go", OP_BR, 0, 0, 0, I_SLOT);
    check("br_n.pc", f_pc, 32'h300C);

    // stall over a taken branch
    do_reset("stl");
    step("stl.f1", OP_PC4, 0, 0, 0, 32'h0);
    step("stl.f2", OP_PC4, 0, 0, 0, I_BR);
    step("stl.s1", OP_BR, 1, 0, 1, I_SLOT);
    check("stl.s1_pc", f_pc, 32'h3008); check("stl.s1_dpc", d_pc, 32'h3004);
    step("stl.s2", OP_BR, 1, 0, 1, I_SLOT);
    check("stl.s2_pc", f_pc, 32'h3008); check("stl.s2_ins", d_instr, I_BR);
    step("stl.go", OP_BR, 1, 0, 0, I_SLOT);
    check("stl.target", f_pc, 32'h3000); check("stl.dpc", d_pc, 32'h3008);

    // jal then jr
    do_reset("jal");
    step("jal.f1", OP_PC4, 0, 0, 0, 32'h0);
    step("jal.f2", OP_PC4, 0, 0, 0, 32'h0);
    step("jal.f3", OP_PC4, 0, 0, 0, 32'h0);
    step("jal.f4", OP_PC4, 0, 0, 0, I_JAL);
    check("jal.dpc", d_pc, 32'h300C);
    check("jal.link", d_pc8, 32'h3014);
    step("jal.go", OP_J, 0, 0, 0, I_SLOT);
    check("jal.target", f_pc, 32'h3040);
    step("jr.go", OP_JR, 0, 32'h3014, 0, 32'h0);
    check("jr.target", f_pc, 32'h3014);

    // wrap-around and reset discarding a pending branch
    step("wrap.jr", OP_JR, 0, 32'hFFFF_FFFC, 0, 32'h0);
    check("wrap.pre", f_pc, 32'hFFFF_FFFC);
    step("wrap.pc4", OP_PC4, 0, 0, 0, I_BR);
    check("wrap.zero", f_pc, 32'h0);
    do_reset("mid_br");
    step("mid_br.first", OP_PC4, 0, 0, 0, 32'h0);
    check("mid_br.pc", f_pc, 32'h3004); check("mid_br.dpc", d_pc, 32'h3000);

    // random stimulus against the model
    for (int i = 0; i < 400; i++) begin
      step("rand",
           2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)),
           (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : $urandom),
           ($urandom_range(0, 3) == 0),
           $urandom);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
